wb_spram: RTL and testbench

- Wishbone B3 slave wrapping a single-port, byte-writable synchronous RAM.
- Serves classic single accesses and registered-feedback bursts: constant-address, incrementing linear, and wrap-4/8/16.
- Used as on-chip scratch/program memory behind an MSI Wishbone interconnect.
- Addresses are byte addresses; storage is 32-bit words.

---
 rtl/wb_spram.sv | 94 +++++++++
 tb/tb_wb_spram.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/wb_spram.sv
// rtl/wb_spram.sv - Wishbone B3 slave over a byte-writable single-port RAM
// Supports classic cycles and registered-feedback constant/linear/wrap bursts.
module wb_spram #(
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic [AW-1:0] wb_adr_i,
  input  logic [31:0]   wb_dat_i,
  input  logic [3:0]    wb_sel_i,
  input  logic          wb_we_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic [2:0]    wb_cti_i,
  input  logic [1:0]    wb_bte_i,
  output logic [31:0]   wb_dat_o,
  output logic          wb_ack_o,
  output logic          wb_err_o
);

  localparam int WORDS = DEPTH / 4;
  localparam int WW    = AW - 2;

  logic [31:0]   mem [WORDS];
  logic          ack_q, ack_d;
  logic [WW-1:0] addr_q, addr_d;
  logic [31:0]   dat_q, dat_d;
  logic          valid, burst, wr_en;
  logic [WW-1:0] wrap_mask, nxt_idx;
  logic [31:0]   rd_word;

  always_comb begin
    valid = wb_cyc_i & wb_stb_i;
    burst = (wb_cti_i == 3'b001) || (wb_cti_i == 3'b010);
    ack_d = valid & (~ack_q | burst);
    wr_en = ack_q & valid & wb_we_i;

    // Wrap bursts only advance the low word-index bits inside their aligned block.
    case (wb_bte_i)
      2'b01:   wrap_mask = WW'(32'd3);
      2'b10:   wrap_mask = WW'(32'd7);
      2'b11:   wrap_mask = WW'(32'd15);
      default: wrap_mask = '1;
    endcase

    if (wb_cti_i == 3'b001) begin
      nxt_idx = addr_q;
    end else begin
      nxt_idx = (addr_q & ~wrap_mask) | ((addr_q + WW'(1)) & wrap_mask);
    end

    addr_d = addr_q;
    if (ack_d) begin
      addr_d = ack_q ? nxt_idx : wb_adr_i[AW-1:2];
    end

    // Forward bytes written on this edge so a constant burst never sees stale data.
    rd_word = mem[addr_d];
    for (int i = 0; i < 4; i++) begin
      if (wr_en && wb_sel_i[i] && (addr_q == addr_d)) begin
        rd_word[8*i +: 8] = wb_dat_i[8*i +: 8];
      end
    end

    dat_d = ack_d ? rd_word : dat_q;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      ack_q  <= 1'b0;
      addr_q <= '0;
      dat_q  <= '0;
    end else begin
      ack_q  <= ack_d;
      addr_q <= addr_d;
      dat_q  <= dat_d;
    end
  end

  // Storage is deliberately outside the reset domain: contents survive reset.
  always_ff @(posedge wb_clk_i) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_en && wb_sel_i[i]) begin
        mem[addr_q][8*i +: 8] <= wb_dat_i[8*i +: 8];
      end
    end
  end

  assign wb_dat_o = dat_q;
  assign wb_ack_o = ack_q;
  assign wb_err_o = 1'b0;

endmodule

// File: tb/tb_wb_spram.sv
// tb/tb_wb_spram.sv - directed and random checks of wb_spram against a word model
module tb_wb_spram;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  adr_i;
  logic [31:0] dat_i;
  logic [3:0]  sel_i;
  logic        we_i, cyc_i, stb_i;
  logic [2:0]  cti_i;
  logic [1:0]  bte_i;
  logic [31:0] dat_o;
  logic        ack_o, err_o;

  int checks   = 0;
  int failures = 0;

  logic [31:0] ref_mem [256];
  logic [31:0] wbuf [16];
  logic [31:0] rbuf [16];
  logic [3:0]  sel_g;

  wb_spram #(.DEPTH(1024)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst_n),
    .wb_adr_i (adr_i),
    .wb_dat_i (dat_i),
    .wb_sel_i (sel_i),
    .wb_we_i  (we_i),
    .wb_cyc_i (cyc_i),
    .wb_stb_i (stb_i),
    .wb_cti_i (cti_i),
    .wb_bte_i (bte_i),
    .wb_dat_o (dat_o),
    .wb_ack_o (ack_o),
    .wb_err_o (err_o)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] next_a(input logic [9:0] a, input logic [2:0] cti,
                                        input logic [1:0] bte);
    logic [9:0] al, blk;
    al = {a[9:2], 2'b00};
    if (cti == 3'b001) return al;
    if (bte == 2'b00) return al + 10'd4;
    blk = 10'((8 << bte) - 1);
    return (al & ~blk) | ((al + 10'd4) & blk);
  endfunction

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Runs an n-beat transfer; cti is 000 (classic), 001 or 010, last beat uses 111.
  task automatic xfer(input logic [9:0] adr, input logic we, input logic [2:0] cti,
                      input logic [1:0] bte, input int n);
    int beat, waitc;
    logic [9:0] a;
    a = adr; beat = 0; waitc = 0;
    cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = a; sel_i = sel_g;
    dat_i = wbuf[0]; bte_i = bte;
    cti_i = (n == 1 && cti != 3'b000) ? 3'b111 : cti;
    while (beat < n) begin
      @(negedge clk);
      if (ack_o) begin
        check1("err_low", err_o, 1'b0);
        if (!we) begin
          rbuf[beat] = dat_o;
          check32("read_model", dat_o, ref_mem[a[9:2]]);
        end else begin
          for (int i = 0; i < 4; i++)
            if (sel_g[i]) ref_mem[a[9:2]][8*i +: 8] = wbuf[beat][8*i +: 8];
        end
        beat++;
        a = next_a(a, cti, bte);
        @(posedge clk); #1;
        if (beat < n) begin
          adr_i = a;
          dat_i = wbuf[beat];
          cti_i = (beat == n - 1) ? 3'b111 : cti;
        end
      end else begin
        if (beat > 0) check1("ack_contiguous", ack_o, 1'b1);
        waitc++;
        if (waitc > 20) begin
          check1("ack_timeout", ack_o, 1'b1);
          beat = n;
        end
        @(posedge clk); #1;
      end
    end
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; cti_i = 3'b000;
    @(negedge clk);
    check1("ack_drop", ack_o, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    adr_i = '0; dat_i = '0; sel_i = '0; we_i = 1'b0;
    cyc_i = 1'b0; stb_i = 1'b0; cti_i = '0; bte_i = '0;
    sel_g = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    check1("reset_ack", ack_o, 1'b0);
    check32("reset_dat", dat_o, 32'h0);
    check1("reset_err", err_o, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill the whole RAM so the model is fully defined.
    for (int b = 0; b < 64; b++) begin
      for (int i = 0; i < 4; i++) wbuf[i] = $urandom;
      xfer(10'(b * 16), 1'b1, 3'b010, 2'b00, 4);
    end

    wbuf[0] = 32'hDEADBEEF;
    xfer(10'h010, 1'b1, 3'b000, 2'b00, 1);
    xfer(10'h010, 1'b0, 3'b000, 2'b00, 1);
    check32("classic_rd", rbuf[0], 32'hDEADBEEF);

    sel_g = 4'b0101; wbuf[0] = 32'h11223344;
    xfer(10'h010, 1'b1, 3'b000, 2'b00, 1);
    sel_g = 4'hF;
    xfer(10'h010, 1'b0, 3'b000, 2'b00, 1);
    check32("byte_en", rbuf[0], 32'hDE22BE44);

    for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
    xfer(10'h020, 1'b1, 3'b010, 2'b00, 4);
    for (int i = 0; i < 4; i++) begin
      xfer(10'(10'h020 + 4 * i), 1'b0, 3'b000, 2'b00, 1);
      check32("linear_rd", rbuf[0], 32'(i + 1));
    end

    for (int i = 0; i < 4; i++) wbuf[i] = 32'(32'hA0 + i);
    xfer(10'h030, 1'b1, 3'b010, 2'b00, 4);
    xfer(10'h038, 1'b0, 3'b010, 2'b01, 4);
    check32("wrap4_b0", rbuf[0], 32'hA2);
    check32("wrap4_b1", rbuf[1], 32'hA3);
    check32("wrap4_b2", rbuf[2], 32'hA0);
    check32("wrap4_b3", rbuf[3], 32'hA1);

    // Reset during beat 2 of a burst write.
    wbuf[0] = 32'h0; wbuf[1] = 32'h0;
    xfer(10'h040, 1'b1, 3'b010, 2'b00, 2);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; sel_i = 4'hF; cti_i = 3'b010;
    bte_i = 2'b00; adr_i = 10'h040; dat_i = 32'h0BEEF001;
    @(posedge clk); #1;
    @(negedge clk);
    check1("rst_beat1_ack", ack_o, 1'b1);
    @(posedge clk); #1;
    adr_i = 10'h044; dat_i = 32'h0BEEF002;
    @(negedge clk);
    check1("rst_beat2_ack", ack_o, 1'b1);
    rst_n = 1'b0;
    #1;
    check1("rst_ack_now", ack_o, 1'b0);
    check1("rst_err", err_o, 1'b0);
    ref_mem[8'h10] = 32'h0BEEF001;
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; cti_i = 3'b000;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    xfer(10'h040, 1'b0, 3'b000, 2'b00, 1);
    check32("rst_beat1_kept", rbuf[0], 32'h0BEEF001);
    xfer(10'h044, 1'b0, 3'b000, 2'b00, 1);
    check32("rst_beat2_dropped", rbuf[0], 32'h0);

    for (int t = 0; t < 1000; t++) begin
      int kind, n;
      logic [2:0] cti;
      kind  = $urandom_range(0, 2);
      n     = (kind == 0) ? 1 : $urandom_range(1, 8);
      cti   = (kind == 0) ? 3'b000 : (kind == 1) ? 3'b001 : 3'b010;
      sel_g = 4'($urandom);
      for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
      xfer(10'($urandom), 1'($urandom), cti, 2'($urandom), n);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
